// File: rtl/pa_feeder.sv
// pa_feeder: paired v/h row buffer feeding a systolic array.
// Rows are written as one v/h entry into a circular buffer and popped one
// per read_en_i into registered output buses. data_rdy_o flags a full tile.
// Optional build macro: PA_FEEDER_UNDERFLOW_FLAG_EN adds a sticky underflow_o.
module pa_feeder #(
    parameter int SIZE_MAT   = 16,
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic                             wr_valid_i,
    output logic                             wr_ready_o,
    input  logic [SIZE_MAT*WIDTH_DATA-1:0]   wr_v_i,
    input  logic [SIZE_MAT*WIDTH_DATA-1:0]   wr_h_i,
    output logic                             data_rdy_o,
    input  logic                             read_en_i,
    output logic [SIZE_MAT*WIDTH_DATA-1:0]   v_bus_o,
    output logic [SIZE_MAT*WIDTH_DATA-1:0]   h_bus_o,
    output logic [$clog2(DEPTH):0]           count_o
`ifdef PA_FEEDER_UNDERFLOW_FLAG_EN
    ,
    output logic                             underflow_o
`endif
);

    localparam int BW = SIZE_MAT * WIDTH_DATA;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] TILE_C  = CW'(SIZE_MAT);

    logic [BW-1:0]   mem_v [DEPTH];
    logic [BW-1:0]   mem_h [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_nxt;
    logic            wr_acc;
    logic            pop;

    // Handshake qualification; flush suppresses both write and pop.
    always_comb begin
        wr_acc = wr_valid_i && wr_ready_o && !flush_i;
        pop    = read_en_i && (count_o != '0) && !flush_i;
    end

    // Next occupancy; ready/tile flags are registered from this value.
    always_comb begin
        count_nxt = count_o;
        if (flush_i) begin
            count_nxt = '0;
        end else if (wr_acc && !pop) begin
            count_nxt = count_o + CW'(1);
        end else if (pop && !wr_acc) begin
            count_nxt = count_o - CW'(1);
        end
    end

    // Row storage; contents only change on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_v[wr_ptr] <= wr_v_i;
            mem_h[wr_ptr] <= wr_h_i;
        end
    end

    // Pointers, occupancy, status flags and registered output buses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            wr_ready_o <= 1'b1;
            data_rdy_o <= 1'b0;
            v_bus_o    <= '0;
            h_bus_o    <= '0;
        end else begin
            count_o    <= count_nxt;
            wr_ready_o <= (count_nxt < DEPTH_C);
            data_rdy_o <= (count_nxt >= TILE_C);
            if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                v_bus_o <= '0;
                h_bus_o <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + AW'(1);
                    v_bus_o <= mem_v[rd_ptr];
                    h_bus_o <= mem_h[rd_ptr];
                end
            end
        end
    end

`ifdef PA_FEEDER_UNDERFLOW_FLAG_EN
    // Sticky record of any pop request against an empty buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            underflow_o <= 1'b0;
        end else if (read_en_i && (count_o == '0)) begin
            underflow_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pa_feeder.sv
// Testbench for pa_feeder: table-driven segments plus reset/flush sequences,
// with a queue scoreboard predicting every popped row.
module tb_pa_feeder;

    localparam int SM = 16;
    localparam int WD = 16;
    localparam int DP = 32;
    localparam int BW = SM * WD;
    localparam int CW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [BW-1:0] wr_v_i;
    logic [BW-1:0] wr_h_i;
    logic          data_rdy_o;
    logic          read_en_i;
    logic [BW-1:0] v_bus_o;
    logic [BW-1:0] h_bus_o;
    logic [CW-1:0] count_o;
`ifdef PA_FEEDER_UNDERFLOW_FLAG_EN
    logic          underflow_o;
`endif

    pa_feeder #(.SIZE_MAT(SM), .WIDTH_DATA(WD), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_v_i     (wr_v_i),
        .wr_h_i     (wr_h_i),
        .data_rdy_o (data_rdy_o),
        .read_en_i  (read_en_i),
        .v_bus_o    (v_bus_o),
        .h_bus_o    (h_bus_o),
        .count_o    (count_o)
`ifdef PA_FEEDER_UNDERFLOW_FLAG_EN
        ,
        .underflow_o(underflow_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic wr;
        logic rd;
        logic fl;
        int   n;
        int   exp_count;
        logic exp_ready;
        logic exp_rdy;
    } vec_t;

    vec_t          tbl [8];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            m_count;
    int            next_id;
    logic          m_uf;
    logic [BW-1:0] q_v [$];
    logic [BW-1:0] q_h [$];
    logic [BW-1:0] exp_v;
    logic [BW-1:0] exp_h;

    function automatic logic [BW-1:0] mk_v(input int i);
        logic [BW-1:0] r;
        for (int j = 0; j < SM; j++) r[j*WD +: WD] = 16'(j + i);
        return r;
    endfunction

    function automatic logic [BW-1:0] mk_h(input int i);
        logic [BW-1:0] r;
        for (int j = 0; j < SM; j++) r[j*WD +: WD] = 16'(j + i + 16'h1000);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk_bus({tag, " v_bus"}, v_bus_o, exp_v);
        chk_bus({tag, " h_bus"}, h_bus_o, exp_h);
        chk({tag, " count"}, int'(count_o), m_count);
        chk({tag, " wr_ready"}, int'(wr_ready_o), (m_count < DP) ? 1 : 0);
        chk({tag, " data_rdy"}, int'(data_rdy_o), (m_count >= SM) ? 1 : 0);
`ifdef PA_FEEDER_UNDERFLOW_FLAG_EN
        chk({tag, " underflow"}, int'(underflow_o), int'(m_uf));
`endif
    endtask

    task automatic model_clear();
        q_v.delete();
        q_h.delete();
        m_count = 0;
        exp_v   = '0;
        exp_h   = '0;
        m_uf    = 1'b0;
    endtask

    // One clock: drive inputs, predict, then compare just after the edge.
    task automatic step(input logic wr, input logic rd, input logic fl, input string tag);
        logic acc;
        logic pp;
        wr_valid_i = wr;
        read_en_i  = rd;
        flush_i    = fl;
        wr_v_i     = mk_v(next_id);
        wr_h_i     = mk_h(next_id);
        acc = wr && (m_count < DP) && !fl;
        pp  = rd && (m_count > 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            model_clear();
        end else begin
            if (rd && m_count == 0) m_uf = 1'b1;
            if (pp) begin
                exp_v = q_v.pop_front();
                exp_h = q_h.pop_front();
                m_count--;
            end
            if (acc) begin
                q_v.push_back(mk_v(next_id));
                q_h.push_back(mk_h(next_id));
                next_id++;
                m_count++;
            end
        end
        chk_all(tag);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16, 16, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 16,  0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0,  2,  0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32, 32, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0,  1, 31, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 40, 31, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 31,  0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 10, 10, 1'b1, 1'b0};

        rst        = 1'b1;
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        read_en_i  = 1'b0;
        wr_v_i     = '0;
        wr_h_i     = '0;
        next_id    = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("reset");

        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < tbl[s].n; k++) begin
                step(tbl[s].wr, tbl[s].rd, tbl[s].fl, $sformatf("seg%0d.%0d", s, k));
            end
            chk($sformatf("seg%0d end count", s), int'(count_o), tbl[s].exp_count);
            chk($sformatf("seg%0d end wr_ready", s), int'(wr_ready_o), int'(tbl[s].exp_ready));
            chk($sformatf("seg%0d end data_rdy", s), int'(data_rdy_o), int'(tbl[s].exp_rdy));
        end

        // Reset pulse with 10 rows buffered.
        wr_valid_i = 1'b0;
        read_en_i  = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk("rst mid count", int'(count_o), 0);
        chk_bus("rst mid v_bus", v_bus_o, '0);
        chk("rst mid wr_ready", int'(wr_ready_o), 1);
        chk_all("post_rst");

        // Buffer resumes empty, then flush wins over a simultaneous write.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, $sformatf("refill%0d", k));
        step(1'b0, 1'b1, 1'b0, "pop_one");
        step(1'b1, 1'b0, 1'b1, "flush_wr");
        chk("flush count", int'(count_o), 0);
        chk_bus("flush h_bus", h_bus_o, '0);
        step(1'b0, 1'b1, 1'b0, "uf_after_flush");
        step(1'b1, 1'b0, 1'b0, "wr_after_uf");
        step(1'b0, 1'b0, 1'b1, "flush_clr");
        step(1'b0, 1'b0, 1'b0, "idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
